// File: rtl/transfer_pkg.sv
// Shared constants and helpers for the transfer register.
// Lane width and lowest-active-lane search.
package transfer_pkg;

   localparam int BYTE_W    = 8;
   localparam int MAX_LANES = 32;

   // Index of the lowest set bit in v; 0 when none is set.
   function automatic int lowest_lane(input logic [MAX_LANES-1:0] v);
      int idx;
      idx = 0;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/transfer_reg_v2_if.sv
// Bus bundle for transfer_reg_v2: system, transfer and address buses.
// Adds the swap strobe when TRANSFER_REG_SHADOW_EN is defined.
interface transfer_reg_v2_if
   import transfer_pkg::*;
#(
   parameter int WIDTH = 16
);
   localparam int BYTES = WIDTH / BYTE_W;

   logic [BYTE_W-1:0] main_in;
   logic [BYTE_W-1:0] main_out;
   logic              main_oe;
   logic [WIDTH-1:0]  xfer_in;
   logic [WIDTH-1:0]  xfer_out;
   logic              xfer_oe;
   logic [WIDTH-1:0]  addr_out;
   logic              addr_oe;
   logic [BYTES-1:0]  ld_byte_n;
   logic [BYTES-1:0]  rd_byte_n;
   logic              ld_xfer_n;
   logic              a_xfer_n;
   logic              a_addr_n;
   logic              inc;
   logic              dec;
   logic [WIDTH-1:0]  q;
   logic              err;
`ifdef TRANSFER_REG_SHADOW_EN
   logic              swap;
`endif

   modport master (
      output main_in, xfer_in, ld_byte_n, rd_byte_n,
      output ld_xfer_n, a_xfer_n, a_addr_n, inc, dec,
`ifdef TRANSFER_REG_SHADOW_EN
      output swap,
`endif
      input  main_out, main_oe, xfer_out, xfer_oe,
      input  addr_out, addr_oe, q, err
   );

   modport slave (
      input  main_in, xfer_in, ld_byte_n, rd_byte_n,
      input  ld_xfer_n, a_xfer_n, a_addr_n, inc, dec,
`ifdef TRANSFER_REG_SHADOW_EN
      input  swap,
`endif
      output main_out, main_oe, xfer_out, xfer_oe,
      output addr_out, addr_oe, q, err
   );

endinterface

// File: rtl/xfer_byte_lane.sv
// One 8-bit lane of the transfer register.
// Loads d_i when ld_i, otherwise holds; drives rd_o only when selected.
module xfer_byte_lane
   import transfer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_i,
   input  logic [BYTE_W-1:0] d_i,
   input  logic              sel_i,
   output logic [BYTE_W-1:0] q_o,
   output logic [BYTE_W-1:0] rd_o
);

   logic [BYTE_W-1:0] byte_q;
   logic [BYTE_W-1:0] byte_d;

   // Next lane value: load or hold.
   always_comb begin
      byte_d = byte_q;
      if (ld_i) byte_d = d_i;
   end

   // Lane storage with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) byte_q <= '0;
      else     byte_q <= byte_d;
   end

   assign q_o  = byte_q;
   assign rd_o = sel_i ? byte_q : '0;

endmodule

// File: rtl/transfer_reg_v2.sv
// Byte-addressable transfer register with inc/dec and bus drivers.
// Optional shadow register and swap under TRANSFER_REG_SHADOW_EN.
module transfer_reg_v2
   import transfer_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   transfer_reg_v2_if.slave bus
);

   localparam int BYTES = WIDTH / BYTE_W;

   logic [WIDTH-1:0]             q_w;
   logic [WIDTH-1:0]             step_v;
   logic [WIDTH-1:0]             lane_d;
   logic [BYTES-1:0]             lane_ld;
   logic [BYTES-1:0]             lane_sel;
   logic [BYTES-1:0][BYTE_W-1:0] lane_rd;
   logic [BYTES-1:0]             rd_low;
   logic [BYTES-1:0]             ld_low;
   logic [MAX_LANES-1:0]         rd_vec;
   int                           rd_idx;
   logic                         multi_rd;
   logic                         err_q;
   logic                         err_d;
   logic [BYTE_W-1:0]            main_v;
`ifdef TRANSFER_REG_SHADOW_EN
   logic [WIDTH-1:0]             shadow_q;
   logic [WIDTH-1:0]             shadow_d;
`endif

   assign rd_low = ~bus.rd_byte_n;
   assign ld_low = ~bus.ld_byte_n;

   // Pick the lowest active read lane for the system bus.
   always_comb begin
      rd_vec = '0;
      rd_vec[BYTES-1:0] = rd_low;
      rd_idx = lowest_lane(rd_vec);
      for (int k = 0; k < BYTES; k++) begin
         lane_sel[k] = rd_low[k] && (rd_idx == k);
      end
   end

   // Up/down step; only used when exactly one of inc/dec is set.
   always_comb begin
      step_v = bus.inc ? q_w + WIDTH'(1) : q_w - WIDTH'(1);
   end

   // Prioritised update: swap > xfer load > byte loads > step > hold.
   always_comb begin
      lane_ld = '0;
      lane_d  = q_w;
`ifdef TRANSFER_REG_SHADOW_EN
      shadow_d = shadow_q;
      if (bus.swap) begin
         lane_ld  = '1;
         lane_d   = shadow_q;
         shadow_d = q_w;
      end else
`endif
      if (!bus.ld_xfer_n) begin
         lane_ld = '1;
         lane_d  = bus.xfer_in;
      end else if (|ld_low) begin
         lane_ld = ld_low;
         lane_d  = {BYTES{bus.main_in}};
      end else if (bus.inc ^ bus.dec) begin
         lane_ld = '1;
         lane_d  = step_v;
      end
   end

   genvar k;
   generate
      for (k = 0; k < BYTES; k++) begin : g_lane
         xfer_byte_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .ld_i  (lane_ld[k]),
            .d_i   (lane_d[k*BYTE_W +: BYTE_W]),
            .sel_i (lane_sel[k]),
            .q_o   (q_w[k*BYTE_W +: BYTE_W]),
            .rd_o  (lane_rd[k])
         );
      end
   endgenerate

`ifdef TRANSFER_REG_SHADOW_EN
   // Shadow copy, exchanged with q on swap.
   always_ff @(posedge clk) begin
      if (rst) shadow_q <= '0;
      else     shadow_q <= shadow_d;
   end
`endif

   // Sticky bus-conflict detection.
   always_comb begin
      multi_rd = |(rd_low & (rd_low - BYTES'(1)));
      err_d    = err_q | multi_rd | (!bus.ld_xfer_n && !bus.a_xfer_n);
   end

   // Conflict flag holds until reset.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   // Merge lane read outputs; at most the selected lane is non-zero.
   always_comb begin
      main_v = '0;
      for (int i = 0; i < BYTES; i++) begin
         main_v = main_v | lane_rd[i];
      end
   end

   assign bus.main_out = main_v;
   assign bus.main_oe  = |rd_low;
   assign bus.xfer_out = q_w;
   assign bus.xfer_oe  = !bus.a_xfer_n;
   assign bus.addr_out = q_w;
   assign bus.addr_oe  = !bus.a_addr_n;
   assign bus.q        = q_w;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_transfer_reg_v2.sv
// Directed bench for transfer_reg_v2 (WIDTH=16).
// Covers shadow/swap when TRANSFER_REG_SHADOW_EN is defined.
module tb_transfer_reg_v2;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   transfer_reg_v2_if #(.WIDTH(16)) bus ();

   transfer_reg_v2 #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.main_in   = 8'h00;
      bus.xfer_in   = 16'h0000;
      bus.ld_byte_n = 2'b11;
      bus.rd_byte_n = 2'b11;
      bus.ld_xfer_n = 1'b1;
      bus.a_xfer_n  = 1'b1;
      bus.a_addr_n  = 1'b1;
      bus.inc       = 1'b0;
      bus.dec       = 1'b0;
`ifdef TRANSFER_REG_SHADOW_EN
      bus.swap      = 1'b0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] v);
      idle();
      bus.ld_xfer_n = 1'b0;
      bus.xfer_in   = v;
      step();
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      rst = 1'b1;
      bus.inc = 1'b1;
      bus.a_addr_n = 1'b0;
      #1;
      chk("oe_in_rst", bus.addr_oe, 1);
      step();
      step();
      chk("rst_q", bus.q, 16'h0000);
      chk("rst_err", bus.err, 0);
      rst = 1'b0;
      idle();

      bus.ld_xfer_n = 1'b0;
      bus.xfer_in   = 16'hBEEF;
      bus.inc       = 1'b1;
      step();
      idle();
      chk("ldx_q", bus.q, 16'hBEEF);
      bus.a_addr_n = 1'b0;
      #1;
      chk("addr_out", bus.addr_out, 16'hBEEF);
      chk("addr_oe", bus.addr_oe, 1);
      chk("xfer_oe0", bus.xfer_oe, 0);
      idle();
      bus.a_xfer_n = 1'b0;
      #1;
      chk("xfer_out", bus.xfer_out, 16'hBEEF);
      chk("xfer_oe1", bus.xfer_oe, 1);
      idle();

      bus.ld_xfer_n = 1'b0;
      bus.xfer_in   = 16'h5A5A;
      bus.ld_byte_n = 2'b00;
      bus.main_in   = 8'h77;
      step();
      idle();
      chk("ldx_prio", bus.q, 16'h5A5A);

      bus.ld_byte_n = 2'b10;
      bus.main_in   = 8'h34;
      bus.dec       = 1'b1;
      step();
      chk("ldb_lo", bus.q, 16'h5A34);
      bus.ld_byte_n = 2'b01;
      bus.main_in   = 8'h12;
      step();
      chk("ldb_hi", bus.q, 16'h1234);
      bus.ld_byte_n = 2'b00;
      bus.main_in   = 8'hAB;
      step();
      idle();
      chk("ldb_both", bus.q, 16'hABAB);

      load(16'hFFFF);
      bus.inc = 1'b1;
      step();
      chk("inc_wrap", bus.q, 16'h0000);
      idle();
      bus.dec = 1'b1;
      step();
      chk("dec_wrap", bus.q, 16'hFFFF);
      bus.inc = 1'b1;
      step();
      idle();
      chk("inc_dec", bus.q, 16'hFFFF);

      load(16'h00FF);
      bus.a_addr_n = 1'b0;
      bus.inc      = 1'b1;
      #1;
      chk("post_pre", bus.addr_out, 16'h00FF);
      step();
      idle();
      chk("post_q", bus.q, 16'h0100);

      load(16'h12FF);
      bus.rd_byte_n = 2'b10;
      #1;
      chk("rd_lane0", bus.main_out, 8'hFF);
      chk("rd_oe", bus.main_oe, 1);
      bus.rd_byte_n = 2'b01;
      #1;
      chk("rd_lane1", bus.main_out, 8'h12);
      step();
      bus.rd_byte_n = 2'b11;
      #1;
      chk("rd_none", bus.main_out, 8'h00);
      chk("rd_oe0", bus.main_oe, 0);
      chk("err_clean", bus.err, 0);
      bus.rd_byte_n = 2'b00;
      #1;
      chk("rd_multi", bus.main_out, 8'hFF);
      chk("err_pre", bus.err, 0);
      step();
      idle();
      chk("err_set", bus.err, 1);
      bus.inc = 1'b1;
      step();
      step();
      idle();
      chk("err_sticky", bus.err, 1);
      chk("err_noeff", bus.q, 16'h1301);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("err_rst", bus.err, 0);
      chk("q_rst", bus.q, 16'h0000);

      bus.ld_xfer_n = 1'b0;
      bus.a_xfer_n  = 1'b0;
      bus.xfer_in   = 16'h0042;
      step();
      idle();
      chk("err_xfer", bus.err, 1);
      chk("q_xfer", bus.q, 16'h0042);
      rst = 1'b1;
      step();
      rst = 1'b0;

`ifdef TRANSFER_REG_SHADOW_EN
      load(16'h2222);
      bus.swap = 1'b1;
      step();
      idle();
      chk("swap0", bus.q, 16'h0000);
      load(16'h1111);
      bus.swap = 1'b1;
      step();
      idle();
      chk("swap_q", bus.q, 16'h2222);
      bus.swap      = 1'b1;
      bus.inc       = 1'b1;
      bus.ld_xfer_n = 1'b0;
      bus.xfer_in   = 16'h9999;
      step();
      idle();
      chk("swap_prio", bus.q, 16'h1111);
      bus.swap = 1'b1;
      step();
      idle();
      chk("swap_back", bus.q, 16'h2222);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
